qspi_rom_responder: RTL and testbench
=====================================

// Module: qspi_rom_responder
// PURPOSE
//  SPI/QSPI serial-ROM responder: the memory end of the QCPU ROM fetch bus. Decodes the
//  fetch commands the CPU issues and streams bytes from an on-chip byte-wide memory port.
//  Serves as an on-die boot-ROM emulator and as the reference responder in CPU benches.
//  Runs entirely in wb_clk_i. SPI pins are oversampled, so wb_clk_i >= 4x SCLK.
// PARAMETERS
//  ADDR_W       16  memory address width; SPI address bits above ADDR_W are ignored
//  SYNC_STAGES  2   synchroniser depth on cs_n/sclk/di (>=2)
//  DUMMY_CLKS   8   dummy SCLK cycles between address and data for CMD 0x6B
// PORTS
//  wb_clk_i    in   1       system clock
//  wb_rst_i    in   1       asynchronous reset, active-high
//  spi_cs_n    in   1       chip select, active-low
//  spi_sclk    in   1       serial clock, SPI mode 0
//  spi_di      in   4       IO[3:0]; IO0 = MOSI in single mode
//  spi_do      out  4       IO[3:0] drive; IO1 = MISO in single mode
//  spi_oeb     out  4       per-IO output-enable-bar (0 = drive)
//  mem_re      out  1       one-cycle read strobe
//  mem_addr    out  ADDR_W  read address, valid while mem_re=1
//  mem_rdata   in   8       read data, valid the cycle after mem_re
//  busy        out  1       1 while not in IDLE
//  cmd_err     out  1       sticky: unsupported opcode seen; cleared by reset only
// BEHAVIOUR
//  Reset: spi_do=0, spi_oeb=4'hF, mem_re=0, mem_addr=0, busy=0, cmd_err=0, state=IDLE.
//  Sync cs_n/sclk/di through SYNC_STAGES flops. Detect SCLK rise/fall on the synced copy.
//  Sample inputs on SCLK rise. Update spi_do on SCLK fall, or on the data-phase entry cycle.
//  FSM (counters advance on SCLK rise only):
//   IDLE  : cs_n falls -> CMD, bit_cnt=0.
//   CMD   : shift IO0, MSB first, 8 bits. 0x03 -> ADDR(single). 0x6B -> ADDR(quad).
//           Any other opcode -> IGNORE, set cmd_err.
//   ADDR  : shift IO0, 24 bits, MSB first; keep low ADDR_W bits.
//           After bit 24: pulse mem_re at addr. Next state is DATA for 0x03, DUMMY for 0x6B.
//   DUMMY : count DUMMY_CLKS rises, all outputs tristate. Then -> DATA.
//   DATA  : byte loaded into shift reg the cycle after mem_re.
//           Single: MSB on IO1; oeb=4'b1101. Quad: nibble [7:4] on IO[3:0], then [3:0]; oeb=4'h0.
//           First bit/nibble is driven before the next SCLK rise.
//           Each subsequent SCLK fall presents the next bit/nibble.
//           At byte start, addr increments and mem_re is pulsed, so the next byte is ready
//           before the final bit/nibble. Addr wraps 2^ADDR_W-1 -> 0. Streaming is unbounded.
//   IGNORE: outputs tristate until cs_n rises.
//  cs_n high in any state, mid-byte included: -> IDLE within SYNC_STAGES+1 cycles.
//   oeb=4'hF and counters cleared. Any pending mem_re completes, but its data is discarded.
//  cs_n rise and SCLK edge in the same synced cycle: cs_n wins, the edge is ignored.
//  mem_re is never asserted in consecutive cycles. mem_addr holds between strobes.
// STRUCTURE
//  Shared package qcpu_pkg: opcode constants CMD_READ=8'h03, CMD_QREAD=8'h6B;
//  state enum RSP_IDLE/CMD/ADDR/DUMMY/DATA/IGNORE.
//  One sub-module: spi_pin_sync (parameterised synchroniser with rise/fall detect on sclk).
//  Also reused by the peripheral SPI slave.
//  Top holds the FSM, shift registers, address counter and pin drivers.
// TESTING  (memory model returns addr[7:0]^8'hA5, wb_clk_i = 8x SCLK)
//  1. Reset asserted mid-DATA -> outputs at reset values the same cycle; busy=0; next read works.
//  2. 0x03, addr 0x000010, 24 clocks -> MISO 0xB5,0xB4,0xB7; oeb=4'b1101;
//     mem_re once per byte, addr 0x10,0x11,0x12.
//  3. 0x6B, addr 0x000020, 8 dummy -> IO[3:0] nibbles 8,5,8,4 (bytes 0x85,0x84);
//     oeb=4'hF during dummy, 4'h0 in data.
//  4. 0x03 at 0xFFFFFF (ADDR_W=16), 2 bytes -> mem_addr 0xFFFF then 0x0000; data 0x5A,0xA5.
//  5. cs_n raised after 12 address bits -> no mem_re, oeb=4'hF, busy=0; next 0x03 read correct.
//  6. Opcode 0xAB -> cmd_err=1, IO tristate for the whole frame. Next 0x03 read correct
//     with cmd_err still 1.

Source files
------------

// File: rtl/qcpu_pkg.sv
// Shared QCPU definitions: ROM fetch opcodes, responder states and pin-drive helpers.
package qcpu_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'h6B;

  localparam logic [3:0] OEB_OFF    = 4'hF;
  localparam logic [3:0] OEB_SINGLE = 4'b1101;
  localparam logic [3:0] OEB_QUAD   = 4'h0;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_CMD,
    RSP_ADDR,
    RSP_DUMMY,
    RSP_DATA,
    RSP_IGNORE
  } rsp_state_e;

  // First bit (single, on IO1) or high nibble (quad) of a freshly loaded byte.
  function automatic logic [3:0] first_io(input logic [7:0] b, input logic quad);
    if (quad) begin
      return b[7:4];
    end
    return {2'b00, b[7], 1'b0};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for SPI slave pins, with SCLK edge detection on the synced copy.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_n_i,
  input  logic       sclk_i,
  input  logic [3:0] di_i,
  output logic       cs_n_o,
  output logic [3:0] di_o,
  output logic       sclk_rise_o,
  output logic       sclk_fall_o
);

  logic [SYNC_STAGES-1:0]      cs_q;
  logic [SYNC_STAGES-1:0]      sclk_q;
  logic [SYNC_STAGES-1:0][3:0] di_q;
  logic                        sclk_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_q        <= '1;
      sclk_q      <= '0;
      di_q        <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      di_q        <= {di_q[SYNC_STAGES-2:0], di_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  // di travels through the same depth as sclk, so a detected rise sees data aligned to it.
  assign cs_n_o      = cs_q[SYNC_STAGES-1];
  assign di_o        = di_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/qspi_rom_responder.sv
// SPI/QSPI serial-ROM responder: decodes 0x03/0x6B fetches and streams bytes from a
// byte-wide memory port, one byte prefetched ahead of the byte on the wire.
module qspi_rom_responder
  import qcpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_CLKS  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic [3:0]        spi_di,
  output logic [3:0]        spi_do,
  output logic [3:0]        spi_oeb,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS - 1);

  logic       cs_s;
  logic [3:0] di_s;
  logic       rise;
  logic       fall;
  logic       unused_di;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .cs_n_i      (spi_cs_n),
    .sclk_i      (spi_sclk),
    .di_i        (spi_di),
    .cs_n_o      (cs_s),
    .di_o        (di_s),
    .sclk_rise_o (rise),
    .sclk_fall_o (fall)
  );

  // Command, address and dummy phases only ever listen on IO0.
  assign unused_di = ^di_s[3:1];

  rsp_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              quad_q, quad_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              rd_vld_q, rd_vld_d;
  logic              buf_vld_q, buf_vld_d;
  logic              started_q, started_d;
  logic              rose_q, rose_d;
  logic [3:0]        do_q, do_d;
  logic [3:0]        oeb_q, oeb_d;
  logic              cmd_err_q, cmd_err_d;

  logic [7:0]        cmd_sh_q, cmd_sh_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [7:0]        buf_q, buf_d;
  logic [7:0]        sh_q, sh_d;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        byte_len;
  logic              load_byte;

  assign opcode    = {cmd_sh_q[6:0], di_s[0]};
  assign addr_next = {addr_sh_q[ADDR_W-2:0], di_s[0]};
  assign byte_len  = quad_q ? 8'd2 : 8'd8;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= RSP_IDLE;
      cnt_q      <= '0;
      quad_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      buf_vld_q  <= 1'b0;
      started_q  <= 1'b0;
      rose_q     <= 1'b0;
      do_q       <= 4'h0;
      oeb_q      <= OEB_OFF;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quad_q     <= quad_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      rd_vld_q   <= rd_vld_d;
      buf_vld_q  <= buf_vld_d;
      started_q  <= started_d;
      rose_q     <= rose_d;
      do_q       <= do_d;
      oeb_q      <= oeb_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    cmd_sh_q  <= cmd_sh_d;
    addr_sh_q <= addr_sh_d;
    buf_q     <= buf_d;
    sh_q      <= sh_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quad_d     = quad_q;
    mem_addr_d = mem_addr_q;
    mem_re_d   = 1'b0;
    rd_vld_d   = mem_re_q;
    buf_vld_d  = buf_vld_q;
    started_d  = started_q;
    rose_d     = rose_q;
    do_d       = do_q;
    oeb_d      = oeb_q;
    cmd_err_d  = cmd_err_q;
    cmd_sh_d   = cmd_sh_q;
    addr_sh_d  = addr_sh_q;
    buf_d      = buf_q;
    sh_d       = sh_q;
    load_byte  = 1'b0;

    // Deselect beats any SCLK edge seen in the same cycle; in-flight read data is dropped.
    if (state_q != RSP_IDLE && cs_s) begin
      state_d   = RSP_IDLE;
      cnt_d     = '0;
      buf_vld_d = 1'b0;
      started_d = 1'b0;
      rose_d    = 1'b0;
      do_d      = 4'h0;
      oeb_d     = OEB_OFF;
    end else begin
      if (rd_vld_q && (state_q == RSP_DUMMY || state_q == RSP_DATA)) begin
        buf_d     = mem_rdata;
        buf_vld_d = 1'b1;
      end

      unique case (state_q)
        RSP_IDLE: begin
          cnt_d = '0;
          if (!cs_s) begin
            state_d = RSP_CMD;
          end
        end

        RSP_CMD: begin
          if (rise) begin
            cmd_sh_d = opcode;
            cnt_d    = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = '0;
              if (opcode == CMD_READ) begin
                state_d = RSP_ADDR;
                quad_d  = 1'b0;
              end else if (opcode == CMD_QREAD) begin
                state_d = RSP_ADDR;
                quad_d  = 1'b1;
              end else begin
                state_d   = RSP_IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end

        RSP_ADDR: begin
          if (rise) begin
            addr_sh_d = addr_next;
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == 8'd23) begin
              cnt_d      = '0;
              mem_addr_d = addr_next;
              mem_re_d   = 1'b1;
              started_d  = 1'b0;
              rose_d     = 1'b0;
              state_d    = quad_q ? RSP_DUMMY : RSP_DATA;
            end
          end
        end

        RSP_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = '0;
              state_d = RSP_DATA;
            end
          end
        end

        RSP_DATA: begin
          // The fall right after entry is not preceded by a data rise, so it must not shift.
          if (!started_q) begin
            load_byte = buf_vld_q;
          end else if (rise) begin
            rose_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else if (fall && rose_q) begin
            rose_d = 1'b0;
            if (cnt_q == byte_len) begin
              load_byte = 1'b1;
            end else if (quad_q) begin
              sh_d = {sh_q[3:0], 4'h0};
              do_d = sh_q[3:0];
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
              do_d = {2'b00, sh_q[6], 1'b0};
            end
          end
        end

        RSP_IGNORE: begin
          state_d = RSP_IGNORE;
        end

        default: begin
          state_d = RSP_IDLE;
        end
      endcase

      // Byte start: present the buffered byte and fetch the one after it.
      if (load_byte) begin
        sh_d       = buf_q;
        buf_vld_d  = 1'b0;
        started_d  = 1'b1;
        rose_d     = 1'b0;
        cnt_d      = '0;
        do_d       = first_io(buf_q, quad_q);
        oeb_d      = quad_q ? OEB_QUAD : OEB_SINGLE;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        mem_re_d   = 1'b1;
      end
    end
  end

  assign spi_do   = do_q;
  assign spi_oeb  = oeb_q;
  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != RSP_IDLE);
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Bench for qspi_rom_responder: SPI master stimulus, a frame-level expectation model and
// per-rise / per-strobe comparison against it.
module tb_qspi_rom_responder;

  localparam int ADDR_W = 16;
  localparam int SYNC   = 2;
  localparam int DUMMY  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs_n = 1'b1;
  logic              sclk = 1'b0;
  logic [3:0]        di = 4'h0;
  logic [3:0]        spi_do;
  logic [3:0]        spi_oeb;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              busy;
  logic              cmd_err;

  qspi_rom_responder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC),
    .DUMMY_CLKS  (DUMMY)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .spi_cs_n  (cs_n),
    .spi_sclk  (sclk),
    .spi_di    (di),
    .spi_do    (spi_do),
    .spi_oeb   (spi_oeb),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Byte-wide memory: data the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_addr[7:0] ^ 8'hA5;
  end

  typedef struct {
    logic [3:0] oeb;
    logic [3:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] strobe_q[$];
  logic [15:0] strobe_log[$];
  logic [7:0]  rx_bytes[$];
  bit          err_model = 1'b0;
  bit          prev_re = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] o, input logic [3:0] v);
    exp_t e;
    e.oeb = o;
    e.val = v;
    return e;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rxb(input int i);
    if (i < rx_bytes.size()) return rx_bytes[i];
    return 8'hxx;
  endfunction

  function automatic logic [15:0] slog(input int i);
    if (i < strobe_log.size()) return strobe_log[i];
    return 16'hxxxx;
  endfunction

  // Master samples on every SCLK rise; the responder must match the frame expectation.
  always @(posedge sclk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rise_unexpected: got rise with no expectation");
    end else begin
      e = exp_q.pop_front();
      check("oeb_at_rise", spi_oeb, e.oeb);
      check("busy_at_rise", busy, 1);
      if (e.oeb != 4'hF) check("io_at_rise", spi_do & ~e.oeb, e.val & ~e.oeb);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re) begin
        if (prev_re) check("mem_re_back_to_back", prev_re, 0);
        strobe_log.push_back(mem_addr);
        if (strobe_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_re_unexpected: got addr %0h want no strobe", mem_addr);
        end else begin
          check("mem_addr", mem_addr, strobe_q.pop_front());
        end
      end
      prev_re = mem_re;
    end
  end

  task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] s);
    di = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    s = spi_do;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // One chip-select frame; stop_after>0 truncates it, rst_mid ends it with a reset.
  task automatic run_frame(input logic [7:0] op, input logic [23:0] a, input int nbytes,
                           input int stop_after, input bit rst_mid);
    bit          ok_op;
    bit          quad;
    int          len;
    int          ndum;
    int          n;
    int          r;
    int          starts;
    int          idx;
    logic [7:0]  b;
    logic [7:0]  acc;
    logic [3:0]  s;
    logic [3:0]  tx[$];
    exp_t        ex[$];
    ok_op = (op == 8'h03) || (op == 8'h6B);
    quad  = (op == 8'h6B);
    len   = quad ? 2 : 8;
    ndum  = (ok_op && quad) ? DUMMY : 0;
    acc   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tx.push_back({3'b000, op[7-i]});
      ex.push_back(mk(4'hF, 4'h0));
    end
    for (int i = 0; i < 24; i++) begin
      tx.push_back({3'b000, a[23-i]});
      ex.push_back(mk(4'hF, 4'h0));
    end
    for (int i = 0; i < ndum; i++) begin
      tx.push_back(4'h0);
      ex.push_back(mk(4'hF, 4'h0));
    end
    for (int k = 0; k < nbytes; k++) begin
      b = mem_byte(a[15:0] + 16'(k));
      if (!ok_op) begin
        for (int j = 0; j < 8; j++) begin
          tx.push_back(4'h0);
          ex.push_back(mk(4'hF, 4'h0));
        end
      end else if (quad) begin
        tx.push_back(4'h0);
        ex.push_back(mk(4'h0, b[7:4]));
        tx.push_back(4'h0);
        ex.push_back(mk(4'h0, b[3:0]));
      end else begin
        for (int j = 0; j < 8; j++) begin
          tx.push_back(4'h0);
          ex.push_back(mk(4'b1101, {2'b00, b[7-j], 1'b0}));
        end
      end
    end
    n = (stop_after > 0) ? stop_after : tx.size();
    for (int i = 0; i < n; i++) exp_q.push_back(ex[i]);
    // One fetch at address end, then one per byte start (each byte prefetches the next).
    if (ok_op && n >= 32) strobe_q.push_back(a[15:0]);
    if (ok_op && n >= 32 + ndum) begin
      r = n - 32 - ndum;
      starts = 1 + r / len;
      for (int k = 1; k <= starts; k++) strobe_q.push_back(a[15:0] + 16'(k));
    end
    if (!ok_op && n >= 8) err_model = 1'b1;

    rx_bytes.delete();
    strobe_log.delete();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sclk_cycle(tx[i], s);
      if (ok_op && i >= 32 + ndum) begin
        idx = i - 32 - ndum;
        acc = quad ? {acc[3:0], s} : {acc[6:0], s[1]};
        if ((idx + 1) % len == 0) rx_bytes.push_back(acc);
      end
    end
    repeat (4) @(negedge clk);
    if (rst_mid) begin
      #2 rst = 1'b1;
      #1;
      check("rst_spi_do", spi_do, 4'h0);
      check("rst_spi_oeb", spi_oeb, 4'hF);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_err", cmd_err, 0);
      cs_n = 1'b1;
      err_model = 1'b0;
      prev_re = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
    end else begin
      cs_n = 1'b1;
    end
    repeat (SYNC + 4) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_oeb", spi_oeb, 4'hF);
    check("end_mem_re", mem_re, 0);
    check("end_cmd_err", cmd_err, err_model);
    check("end_strobes_left", strobe_q.size(), 0);
    check("end_rises_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_spi_do", spi_do, 4'h0);
    check("reset_spi_oeb", spi_oeb, 4'hF);
    check("reset_mem_re", mem_re, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_err", cmd_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the first data byte.
    run_frame(8'h03, 24'h000040, 2, 32 + 4, 1'b1);

    // Single read, three bytes.
    run_frame(8'h03, 24'h000010, 3, 0, 1'b0);
    check("t2_rx_count", rx_bytes.size(), 3);
    check("t2_byte0", rxb(0), 8'hB5);
    check("t2_byte1", rxb(1), 8'hB4);
    check("t2_byte2", rxb(2), 8'hB7);
    check("t2_strobe0", slog(0), 16'h0010);
    check("t2_strobe1", slog(1), 16'h0011);
    check("t2_strobe2", slog(2), 16'h0012);

    // Quad read with dummy cycles.
    run_frame(8'h6B, 24'h000020, 2, 0, 1'b0);
    check("t3_byte0", rxb(0), 8'h85);
    check("t3_byte1", rxb(1), 8'h84);
    check("t3_strobe0", slog(0), 16'h0020);

    // Address wrap at the top of the ADDR_W space.
    run_frame(8'h03, 24'hFFFFFF, 2, 0, 1'b0);
    check("t4_strobe0", slog(0), 16'hFFFF);
    check("t4_strobe1", slog(1), 16'h0000);
    check("t4_byte0", rxb(0), 8'h5A);
    check("t4_byte1", rxb(1), 8'hA5);

    // Deselect after 12 address bits, then a normal read.
    run_frame(8'h03, 24'h000030, 1, 8 + 12, 1'b0);
    check("t5_no_strobe", strobe_log.size(), 0);
    run_frame(8'h03, 24'h000031, 1, 0, 1'b0);
    check("t5_next_byte", rxb(0), 8'h94);

    // Unsupported opcode, then a read with the sticky error still set.
    run_frame(8'hAB, 24'h000000, 2, 0, 1'b0);
    check("t6_cmd_err", cmd_err, 1);
    run_frame(8'h03, 24'h000055, 1, 0, 1'b0);
    check("t6_next_byte", rxb(0), 8'hF0);
    check("t6_cmd_err_sticky", cmd_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
